alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 131 +++++++++++++
 tb/tb_alu_mc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an iterative shift-add multiplier.
// Results and flags are registered and held until the next operation writes them.
module alu_mc #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] R,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             Co,
  output logic             Z
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               co_q, co_d;
  logic               z_q, z_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               accept;
  logic               is_mul;
  logic [WIDTH:0]     alu_res;
  logic [2*WIDTH-1:0] mul_sum;

  assign accept  = start && (state_q != StMul);
  assign is_mul  = MUL_EN && (ALUCode == 4'd7);
  assign mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath; bit WIDTH is carry/borrow, zero for logic ops.
  always_comb begin
    alu_res = '0;
    case (ALUCode)
      4'd0: alu_res = {1'b0, A} + {1'b0, R} + {{WIDTH{1'b0}}, Ci};
      4'd1: alu_res = {1'b0, A} - {1'b0, R} - {{WIDTH{1'b0}}, Ci};
      4'd2: alu_res = {1'b0, A & R};
      4'd3: alu_res = {1'b0, A | R};
      4'd4: alu_res = {1'b0, A ^ R};
      4'd5: alu_res = {1'b0, ~A};
      4'd6: alu_res = {1'b0, R};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    co_d     = co_q;
    z_d      = z_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = R;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            out_d   = alu_res[WIDTH-1:0];
            co_d    = alu_res[WIDTH];
            z_d     = (alu_res[WIDTH-1:0] == '0);
            state_d = StDone;
          end
        end
      end
      StMul: begin
        prod_d   = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Final iteration writes the result straight from the adder.
        if (cnt_q == CntLast) begin
          out_d   = mul_sum[WIDTH-1:0];
          co_d    = |mul_sum[2*WIDTH-1:WIDTH];
          z_d     = (mul_sum[WIDTH-1:0] == '0);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      out_q    <= '0;
      co_q     <= 1'b0;
      z_q      <= 1'b1;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      co_q     <= co_d;
      z_q      <= z_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == StMul);
  assign done = (state_q == StDone);
  assign out  = out_q;
  assign Co   = co_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): vector table, result scoreboard, and
// hand-written sequences for ignored start, mid-multiply reset and reset/start priority.
module tb_alu_mc;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] alu_code;
  logic [7:0] a;
  logic [7:0] r;
  logic       ci;
  logic       busy, done, co, z;
  logic [7:0] dout;
  logic       busy0, done0, co0, z0;
  logic [7:0] dout0;

  alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ALUCode(alu_code), .A(a), .R(r), .Ci(ci),
    .busy(busy), .done(done), .out(dout), .Co(co), .Z(z)
  );

  alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst(rst), .start(start), .ALUCode(alu_code), .A(a), .R(r), .Ci(ci),
    .busy(busy0), .done(done0), .out(dout0), .Co(co0), .Z(z0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [7:0] a;
    logic [7:0] r;
    logic       ci;
    logic [7:0] eo;
    logic       eco;
  } vec_t;

  typedef struct {
    logic [7:0] o;
    logic       co;
    logic       z;
  } exp_t;

  localparam int NumVec = 15;
  vec_t vecs[NumVec];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [7:0] av, input logic [7:0] rv,
                       input logic civ);
    alu_code = c;
    a        = av;
    r        = rv;
    ci       = civ;
    start    = 1'b1;
  endtask

  task automatic push(input logic [7:0] o, input logic cov);
    exp_t e;
    e.o  = o;
    e.co = cov;
    e.z  = (o == 8'h00);
    sb.push_back(e);
    last_out = o;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_out", 32'(dout), 32'(e.o));
        chk("sb_co", 32'(co), 32'(e.co));
        chk("sb_z", 32'(z), 32'(e.z));
      end
    end
  end

  initial begin
    logic [7:0] hold_out;
    vecs[0]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{4'h0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[2]  = '{4'h1, 8'h00, 8'h01, 1'b1, 8'hFE, 1'b1};
    vecs[3]  = '{4'h4, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{4'h1, 8'h50, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[5]  = '{4'h2, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0};
    vecs[6]  = '{4'h3, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{4'h5, 8'h0F, 8'h99, 1'b1, 8'hF0, 1'b0};
    vecs[8]  = '{4'h6, 8'h11, 8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[9]  = '{4'hF, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b0};
    vecs[10] = '{4'h7, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{4'h7, 8'h0F, 8'h11, 1'b1, 8'hFF, 1'b0};
    vecs[12] = '{4'h8, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0};
    vecs[13] = '{4'h7, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs[14] = '{4'h0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

    rst = 1'b1; start = 1'b0; alu_code = 4'h0; a = 8'h00; r = 8'h00; ci = 1'b0;
    last_out = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_z", 32'(z), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].code, vecs[i].a, vecs[i].r, vecs[i].ci);
      push(vecs[i].eo, vecs[i].eco);
      @(negedge clk);
      if (vecs[i].code == 4'h7) begin
        start = 1'b0;
        chk("nomul_done", 32'(done0), 32'd1);
        chk("nomul_out", 32'(dout0), 32'd0);
        chk("nomul_co", 32'(co0), 32'd0);
        chk("nomul_z", 32'(z0), 32'd1);
        for (int k = 0; k < 8; k++) begin
          chk("mul_busy", 32'(busy), 32'd1);
          chk("mul_nodone", 32'(done), 32'd0);
          if (k < 7) @(negedge clk);
        end
        @(negedge clk);
        chk("mul_done", 32'(done), 32'd1);
        chk("mul_busy_end", 32'(busy), 32'd0);
      end else begin
        chk("single_done", 32'(done), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);

    // Start asserted mid-multiply must be ignored; outputs hold the previous result.
    hold_out = last_out;
    drive(4'h7, 8'h03, 8'h05, 1'b0);
    push(8'h0F, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(4'h0, 8'h01, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("hold_out", 32'(dout), 32'(hold_out));
    chk("hold_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("ign_single_pulse", 32'(done), 32'd0);

    // Reset mid-multiply abandons it with no done pulse.
    drive(4'h7, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_out", 32'(dout), 32'd0);
    chk("mrst_co", 32'(co), 32'd0);
    chk("mrst_z", 32'(z), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("mrst_no_done", 32'(done), 32'd0);
    end

    // Reset beats a simultaneous start; the first edge after reset accepts.
    rst = 1'b1;
    drive(4'h0, 8'h12, 8'h34, 1'b1);
    @(negedge clk);
    chk("prio_done", 32'(done), 32'd0);
    chk("prio_out", 32'(dout), 32'd0);
    rst = 1'b0;
    push(8'h47, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_done", 32'(done), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
